ex_muldiv_unit: RTL and testbench

Parametrised RV32M multiply/divide execution unit that sits beside the ALU in the EX stage of the five-stage pipeline.
- Multiply is pipelined with a fixed, configurable latency; divide/remainder is an iterative radix-2 engine.
- While an operation is in flight, the unit raises a stall request that freezes PC, IF/ID and ID/EX.
- On completion it presents result and destination register for one cycle, to be captured into EX/MEM.
- Branch/jump flush aborts an in-flight operation.

---
 rtl/ex_muldiv_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32M multiply/divide execution unit for the EX stage.
//   Multiply runs through a fixed MUL_LAT-cycle wait before its result is
//   registered. Divide/remainder uses a radix-2 restoring engine that works
//   on operand magnitudes. A sign fix-up state follows the divide loop.
// Ports:
//   clock, reset       clock and asynchronous active-high reset
//   start, funct3      issue request and RV32M operation select
//   op_a, op_b, rd_in  operands and destination register of the issuing op
//   flush              aborts any in-flight operation
//   busy               stall request to the hazard logic (combinational)
//   done               one-cycle result-valid pulse
//   result, rd_out     registered result and destination; held after done
module ex_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2,
  parameter int RD_W    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [RD_W-1:0]   rd_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] L_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] L_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] L_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  L_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  L_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  L_DIV_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  L_MUL_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_WAIT = 3'd1,
    S_DIV_ITER = 3'd2,
    S_DIV_FIX  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t              r_state;
  logic [1:0]          r_fn;      // funct3[1:0] of the accepted op
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [RD_W-1:0]     r_rd;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_quo;     // dividend magnitude shifting out, quotient shifting in
  logic [DATA_W-1:0]   r_rem;     // partial remainder
  logic [DATA_W-1:0]   r_div;     // divisor magnitude
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_done;
  logic [DATA_W-1:0]   r_result;
  logic [RD_W-1:0]     r_rd_out;

  // Issue-side decode on the live inputs
  logic                w_accept_state;
  logic                w_work_state;
  logic                w_is_div;
  logic                w_sdiv;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic                w_div_special;

  assign w_accept_state = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_work_state   = (r_state == S_MUL_WAIT) || (r_state == S_DIV_ITER) ||
                          (r_state == S_DIV_FIX);
  assign w_is_div       = funct3[2];
  assign w_sdiv         = ~funct3[0];
  assign w_a_neg        = w_sdiv & op_a[DATA_W-1];
  assign w_b_neg        = w_sdiv & op_b[DATA_W-1];
  assign w_a_mag        = w_a_neg ? (L_ZERO - op_a) : op_a;
  assign w_b_mag        = w_b_neg ? (L_ZERO - op_b) : op_b;
  // Divide by zero and signed overflow skip the iteration loop entirely
  assign w_div_special  = (op_b == L_ZERO) ||
                          (w_sdiv && (op_a == L_MIN) && (op_b == L_ONES));

  assign busy   = ~reset & ((w_accept_state & start & ~flush) | w_work_state);
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;

  // Multiplier: sign-extend each operand to 2*DATA_W as the op requires;
  // the low 2*DATA_W bits of the product are exact for every signedness mix.
  logic                w_mul_sa;
  logic                w_mul_sb;
  logic [2*DATA_W-1:0] w_mul_a;
  logic [2*DATA_W-1:0] w_mul_b;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_mul_res;

  assign w_mul_sa  = (r_fn == 2'b01) || (r_fn == 2'b10);
  assign w_mul_sb  = (r_fn == 2'b01);
  assign w_mul_a   = {{DATA_W{w_mul_sa & r_op_a[DATA_W-1]}}, r_op_a};
  assign w_mul_b   = {{DATA_W{w_mul_sb & r_op_b[DATA_W-1]}}, r_op_b};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = (r_fn == 2'b00) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W];

  // One restoring-division step: shift in the next dividend bit, trial subtract
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_rem_diff;
  logic                w_step_ge;

  assign w_rem_sh   = {r_rem, r_quo[DATA_W-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_div};
  assign w_step_ge  = ~w_rem_diff[DATA_W];

  // Final divide result: special cases first, otherwise apply the sign fix-up
  logic [DATA_W-1:0]   w_fix_q;
  logic [DATA_W-1:0]   w_fix_r;
  logic [DATA_W-1:0]   w_fix_res;

  always_comb begin
    w_fix_q = r_quo;
    w_fix_r = r_rem;
    if (r_op_b == L_ZERO) begin
      w_fix_q = L_ONES;
      w_fix_r = r_op_a;
    end else if (~r_fn[0] && (r_op_a == L_MIN) && (r_op_b == L_ONES)) begin
      w_fix_q = r_op_a;
      w_fix_r = L_ZERO;
    end else begin
      w_fix_q = r_neg_q ? (L_ZERO - r_quo) : r_quo;
      w_fix_r = r_neg_r ? (L_ZERO - r_rem) : r_rem;
    end
  end

  assign w_fix_res = r_fn[1] ? w_fix_r : w_fix_q;

  // Control FSM with registered done/result/rd_out; flush wins over everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_fn     <= 2'b00;
      r_op_a   <= L_ZERO;
      r_op_b   <= L_ZERO;
      r_rd     <= {RD_W{1'b0}};
      r_cnt    <= L_CNT_ZERO;
      r_quo    <= L_ZERO;
      r_rem    <= L_ZERO;
      r_div    <= L_ZERO;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= L_ZERO;
      r_rd_out <= {RD_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (start) begin
            r_fn    <= funct3[1:0];
            r_op_a  <= op_a;
            r_op_b  <= op_b;
            r_rd    <= rd_in;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_rem   <= L_ZERO;
            if (!w_is_div) begin
              r_state <= S_MUL_WAIT;
              r_cnt   <= L_MUL_LAST;
            end else if (w_div_special) begin
              r_state <= S_DIV_FIX;
              r_cnt   <= L_CNT_ZERO;
            end else begin
              r_state <= S_DIV_ITER;
              r_cnt   <= L_DIV_LAST;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == L_CNT_ZERO) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_mul_res;
            r_rd_out <= r_rd;
          end else begin
            r_cnt <= r_cnt - L_CNT_ONE;
          end
        end
        S_DIV_ITER: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_step_ge ? w_rem_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_step_ge};
            if (r_cnt == L_CNT_ZERO) begin
              r_state <= S_DIV_FIX;
            end else begin
              r_cnt <= r_cnt - L_CNT_ONE;
            end
          end
        end
        S_DIV_FIX: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_fix_res;
            r_rd_out <= r_rd;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed cases from the test plan followed by
// randomized operations checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 2;
  localparam int RD_W    = 5;

  logic              clock;
  logic              reset;
  logic              start;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [RD_W-1:0]   rd_in;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [RD_W-1:0]   rd_out;

  int vectors;
  int miscompares;

  ex_muldiv_unit #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .RD_W(RD_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result from the RV32M definitions, using 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint    pa;
    longint    pb;
    logic [63:0] p;
    int        sa;
    int        sb;
    logic      ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin pa = longint'(sa); pb = longint'(sb); p = pa * pb; return p[63:32]; end
      3'd2: begin pa = longint'(sa); pb = longint'({32'd0, b}); p = pa * pb; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (ovf) return a;
        else return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        else if (ovf) return 32'd0;
        else return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        else return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT + 1;
    else if (b == 32'd0) return 2;
    else if (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
    else return DATA_W + 2;
  endfunction

  // Issue one op in the current cycle (called just after a falling edge) and
  // check busy/done every cycle until the expected completion cycle.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int lat);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    #1;
    chk({tag, "_busy_c0"}, 32'(busy), 32'd1);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clock);
      start = 1'b0;
      #1;
      if (c < lat) begin
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
      end else begin
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_rd"}, 32'(rd_out), 32'(rd));
      end
    end
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rrd;
    int          sel;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'd0;
    op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    start = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: MUL with negative operand, then check result holds after done
    do_op("mul7", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 3);
    @(negedge clock); #1;
    chk("hold_done", 32'(done), 32'd0);
    chk("hold_result", result, 32'hFFFF_FFEB);
    chk("hold_rd", 32'(rd_out), 32'd5);

    // 2: high-half multiplies issued back-to-back from DONE
    @(negedge clock);
    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 3);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 3);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 3);

    // 3: iterative divides
    @(negedge clock);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 34);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 34);
    do_op("divu", 3'b101, 32'd100, 32'd7, 5'd8, 32'd14, 34);
    do_op("remu", 3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 34);

    // 4: divide by zero and signed overflow shortcuts
    do_op("divu0", 3'b101, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 2);
    do_op("remu0", 3'b111, 32'd5, 32'd0, 5'd11, 32'd5, 2);
    do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2);
    do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 2);

    // 5: flush a division in cycle 10, then a multiply in cycle 12
    @(negedge clock);
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd14; start = 1'b1;
    #1;
    chk("fl_busy_c0", 32'(busy), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 10) flush = 1'b1;
      #1;
      chk("fl_done_pre", 32'(done), 32'd0);
      chk("fl_busy_pre", 32'(busy), 32'd1);
    end
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("fl_busy_c11", 32'(busy), 32'd0);
    chk("fl_done_c11", 32'(done), 32'd0);
    @(negedge clock);
    do_op("fl_mul", 3'b000, 32'd3, 32'd4, 5'd15, 32'd12, 3);
    for (int c = 0; c < 36; c++) begin
      @(negedge clock); #1;
      chk("fl_no_done", 32'(done), 32'd0);
    end

    // 6: reset in cycle 5 of a division, then start together with flush
    @(negedge clock);
    funct3 = 3'b101; op_a = 32'd999; op_b = 32'd4; rd_in = 5'd16; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_rd", 32'(rd_out), 32'd0);
    start = 1'b1;
    #1;
    chk("mid_rst_busy_start", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd17; start = 1'b1; flush = 1'b1;
    #1;
    chk("sf_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 36; c++) begin
      @(negedge clock);
      start = 1'b0; flush = 1'b0;
      #1;
      chk("sf_no_done", 32'(done), 32'd0);
      chk("sf_busy_idle", 32'(busy), 32'd0);
    end
    chk("sf_result", result, 32'd0);

    // Randomized operations against the reference model
    @(negedge clock);
    for (int n = 0; n < 60; n++) begin
      rf  = 3'($urandom_range(7, 0));
      ra  = $urandom;
      rb  = $urandom;
      rrd = 5'($urandom_range(31, 0));
      sel = $urandom_range(9, 0);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(15, 1));
      else if (sel == 3) ra = 32'($urandom_range(200, 0));
      if ($urandom_range(1, 0) == 1) @(negedge clock);
      do_op("rnd", rf, ra, rb, rrd, ref_op(rf, ra, rb), ref_lat(rf, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
